// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the arbiter and the uart_tx serializer.
// Latency: none (wires only).
// Backpressure: req_ready is a one-cycle accept strobe. tx_busy from the serializer stalls further sends.
//
// Signals:
//   req_valid[N_REQ]   per-requester byte available
//   req_data[8*N_REQ]  requester i byte at [8i+7:8i]
//   req_last[N_REQ]    byte ends a line/message
//   req_ready[N_REQ]   one-cycle accept strobe back to the requester
//   tx_data[8]         byte to uart_tx.data_in
//   tx_send            one-cycle send pulse to uart_tx.send
//   tx_busy            uart_tx.busy
// Modports:
//   master  producers plus serializer (environment side)
//   slave   the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_send;
  logic               tx_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_data, tx_send
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_data, tx_send
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer between N_REQ byte producers.
// Latency: accept in cycle T, tx_send in T+1, next accept the cycle after busy is seen low again.
// Backpressure: one byte per grant; no req_ready while a frame is in flight or while tx_busy is high.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          uart_tx_arbiter_if.slave (requests in, tx_data/tx_send out, tx_busy in)
//   grant_id     index of the last granted requester
//   active       high from accept until the frame (and any EOL bytes) completes
//   sent_count   completed frames, wraps at 16 bits
// Optional feature: define UART_TX_ARBITER_EOL_EN to follow any byte flagged req_last with CR, LF.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus,
  output logic [1:0]       grant_id,
  output logic             active,
  output logic [15:0]      sent_count
);

  localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

`ifdef UART_TX_ARBITER_EOL_EN
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, EOL_CR, EOL_LF} state_t;
  // Which byte of the current grant is on the wire.
  typedef enum logic [1:0] {STG_DATA, STG_CR, STG_LF} stage_t;
  stage_t stage_q;
  logic   last_q;
`else
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        last_grant;
  logic [7:0]        tx_data_q;
  logic [TW-1:0]     to_cnt;
  // Low during the first cycle after reset release so req_ready stays 0 while rst_n is low.
  logic              arb_en;

  logic              found;
  logic [1:0]        winner;
  logic [7:0]        sel_data;
  logic              sel_last;
  logic              accept;
  logic              send;
  logic              frame_done;
  logic [N_REQ-1:0]  rdy;

  // Round-robin pick: first valid index above last_grant, else first valid from 0.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_valid[i] && (i > int'(last_grant))) begin
        found  = 1'b1;
        winner = 2'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found  = 1'b1;
        winner = 2'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(winner) == i) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_last = bus.req_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    send       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && !bus.tx_busy && found) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        send    = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A send the serializer never saw is simply re-pulsed with the same byte.
        if (bus.tx_busy)           state_d = WAIT_DONE;
        else if (to_cnt == TO_LAST) state_d = SEND;
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          frame_done = 1'b1;
          state_d    = IDLE;
`ifdef UART_TX_ARBITER_EOL_EN
          if (stage_q == STG_DATA && last_q) state_d = EOL_CR;
          else if (stage_q == STG_CR)        state_d = EOL_LF;
`endif
        end
      end
`ifdef UART_TX_ARBITER_EOL_EN
      EOL_CR:  state_d = SEND;
      EOL_LF:  state_d = SEND;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rdy[i] = accept && (int'(winner) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en     <= 1'b0;
      last_grant <= 2'(N_REQ - 1);
      grant_id   <= '0;
      tx_data_q  <= '0;
      active     <= 1'b0;
      sent_count <= '0;
      to_cnt     <= '0;
`ifdef UART_TX_ARBITER_EOL_EN
      stage_q    <= STG_DATA;
      last_q     <= 1'b0;
`endif
    end else begin
      arb_en <= 1'b1;
      if (accept) begin
        tx_data_q  <= sel_data;
        grant_id   <= winner;
        last_grant <= winner;
        active     <= 1'b1;
`ifdef UART_TX_ARBITER_EOL_EN
        last_q     <= sel_last;
        stage_q    <= STG_DATA;
`endif
      end
      if (state_q == SEND) begin
        to_cnt <= '0;
      end else if (state_q == WAIT_BUSY && state_d == WAIT_BUSY) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (frame_done) begin
        sent_count <= sent_count + 16'd1;
        if (state_d == IDLE) active <= 1'b0;
      end
`ifdef UART_TX_ARBITER_EOL_EN
      if (state_q == EOL_CR) begin
        tx_data_q <= 8'h0D;
        stage_q   <= STG_CR;
      end
      if (state_q == EOL_LF) begin
        tx_data_q <= 8'h0A;
        stage_q   <= STG_LF;
      end
`endif
    end
  end

`ifndef UART_TX_ARBITER_EOL_EN
  logic unused_last;
  assign unused_last = sel_last;
`endif

  assign bus.req_ready = rdy;
  assign bus.tx_send   = send;
  assign bus.tx_data   = tx_data_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` serializer between several byte producers: the Morse character decoder, the status/echo message generator and the debug dump port. The block arbitrates round-robin, latches one byte per grant and drives the serializer's `data_in`/`send`. It then tracks the serializer's `busy` through one full frame before granting again. It sits between the producers and `uart_tx`; a producer never touches the UART directly.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `BUSY_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after a send pulse before retrying.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte available.
- `req_data` in 8*N_REQ: requester i byte at `[8i+7:8i]`.
- `req_last` in N_REQ: byte is end of line/message. Used only with the EOL feature.
- `req_ready` out N_REQ: one-cycle accept strobe. A transfer occurs when `valid & ready` are both high in the same cycle.
- `tx_data` out 8: byte to `uart_tx.data_in`.
- `tx_send` out 1: one-cycle pulse to `uart_tx.send`.
- `tx_busy` in 1: from `uart_tx.busy`.
- `grant_id` out 2: index of the last granted requester.
- `active` out 1: high from accept until the frame (including any EOL bytes) completes.
- `sent_count` out 16: frames completed, wraps at 0xFFFF→0.

## Operation
- States are IDLE, SEND, WAIT_BUSY, WAIT_DONE, plus EOL_CR and EOL_LF when the feature is enabled.
- **IDLE**
  - Entry requires `tx_busy`=0 and at least one `req_valid`.
  - Pick the winner round-robin, searching from `last_grant+1` modulo N_REQ.
  - Assert that requester's `req_ready` for one cycle, latch its data into `tx_data`, latch `req_last`, set `grant_id`/`last_grant`, set `active`, then go to SEND.
- **SEND**: `tx_send`=1 for exactly one cycle, then go to WAIT_BUSY with the timeout counter cleared.
- **WAIT_BUSY**
  - On `tx_busy`=1, go to WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT-1 without `tx_busy`, return to SEND and re-pulse with the same `tx_data`. Retries are unbounded.
- **WAIT_DONE**
  - On `tx_busy`=0, increment `sent_count`.
  - If the EOL feature is enabled and the latched last flag is set, go to EOL_CR.
  - Otherwise clear `active` and go to IDLE.
- Unselected requesters never see `req_ready`. `req_ready` is never asserted outside IDLE. `req_valid` dropping without a transfer is legal.
- `tx_data` holds its value outside SEND, so `uart_tx` latches a stable value.
- Reset mid-operation aborts immediately and the current byte is lost. `uart_tx` is reset by the same `rst_n`.

## Timing
- Reset values:
  - `req_ready`=0, `tx_send`=0, `tx_data`=0x00, `grant_id`=0, `active`=0, `sent_count`=0.
  - `last_grant`=N_REQ-1, so requester 0 has first priority.
- Accept (ready high) occurs in cycle T. `tx_send` is high in T+1.
- `tx_busy` is expected high in T+2. `uart_tx` registers busy one cycle after seeing send.
- The earliest next accept is the cycle after WAIT_DONE observes `tx_busy`=0. `uart_tx` is then already in IDLE and samples send in the following cycle.
- Simultaneous `req_valid` on all inputs: exactly one grant per frame, rotating 0,1,…,N_REQ-1,0.
- A requester that holds `req_valid` continuously still yields to others that are waiting.

## Configuration
- Macro: `UART_TX_ARBITER_EOL_EN`.
- **Defined**
  - After a frame whose latched `req_last`=1 completes, the block holds the grant and sends 0x0D then 0x0A.
  - Each of these bytes uses the same SEND/WAIT_BUSY/WAIT_DONE sequence (states EOL_CR, EOL_LF) and increments `sent_count`.
  - `active` stays high until the LF frame completes. No `req_ready` is issued during EOL.
- **Undefined**: `req_last` is ignored, the EOL states do not exist and no extra bytes are sent.

## Test plan
- Single byte: after reset, req0 valid with 0x41.
  - `req_ready[0]` pulses in one cycle; `tx_send` is high the next cycle with `tx_data`=0x41.
  - The line carries 0x41 LSB-first; `sent_count`=1 and `active` falls after `tx_busy` falls.
- Contention (N_REQ=2): both requesters hold valid with 0x10 and 0x20 for 4 frames.
  - Sent order is 0x10, 0x20, 0x10, 0x20.
  - `grant_id` sequence is 0,1,0,1 and no byte is duplicated.
- Busy timeout: model `tx_busy` stuck 0 for the first pulse, then respond normally.
  - `tx_send` re-pulses exactly BUSY_TIMEOUT+1 cycles after the first pulse with the same data.
  - `sent_count` increments only once.
- EOL (macro defined): req1 sends 0x53 with `req_last`=1.
  - Wire bytes are 0x53, 0x0D, 0x0A and `sent_count`=3.
  - req0, valid throughout, gets no `req_ready` until after the LF.
- EOL (macro undefined), same stimulus: only 0x53 is sent and `sent_count`=1.
- Reset mid-frame: assert `rst_n`=0 during WAIT_DONE.
  - All outputs return to reset values asynchronously.
  - After release, a pending req0 is granted first.
